// File: rtl/rcas_seq_ctrl_pkg.sv
// Shared constants and encodings for the nibble-serial add/subtract sequencer.
package rcas_seq_ctrl_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rcas_4bit.sv
// 4-bit ripple-carry add/subtract slice; sel=1 inverts b so c_in=1 completes a - b.
module rcas_4bit
    import rcas_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               sel,
    input  logic               c_in,
    output logic [SLICE_W-1:0] result,
    output logic               c_out
);

    logic w_c;
    logic w_bx;

    always_comb begin
        w_c    = c_in;
        w_bx   = 1'b0;
        result = '0;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            w_bx      = b[i] ^ sel;
            result[i] = a[i] ^ w_bx ^ w_c;
            w_c       = (a[i] & w_bx) | (w_c & (a[i] ^ w_bx));
        end
        c_out = w_c;
    end

endmodule

// File: rtl/rcas_seq_ctrl.sv
// Runs a WIDTH-bit add/subtract through one 4-bit slice, one nibble per clock, LSB first.
module rcas_seq_ctrl
    import rcas_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NIBBLES = WIDTH / SLICE_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_e r_state;
    state_e w_state_d;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sel;
    logic               r_carry;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_c_out;
    logic               r_ovf;
    logic               r_done;

    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_c;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

    rcas_4bit u_slice (
        .a      (r_a[SLICE_W-1:0]),
        .b      (r_b[SLICE_W-1:0]),
        .sel    (r_sel),
        .c_in   (r_carry),
        .result (w_slice_sum),
        .c_out  (w_slice_c)
    );

    // Right-shift fill: after NIBBLES shifts the first nibble lands at bit 0.
    assign w_acc_next = {w_slice_sum, r_acc[WIDTH-1:SLICE_W]};
    assign w_last     = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (start) w_state_d = StRun;
            StRun:   if (w_last) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_sel    <= 1'b0;
            r_carry  <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_c_out  <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_done  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sel   <= sel;
                        r_carry <= (sel == OP_SUB);
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end
                end
                StRun: begin
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_carry <= w_slice_c;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_c_out  <= w_slice_c;
                        r_ovf    <= (r_a_msb == (r_b_msb ^ r_sel)) &&
                                    (w_slice_sum[SLICE_W-1] != r_a_msb);
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = (r_state == StIdle);
    assign busy   = (r_state == StRun);
    assign done   = r_done;
    assign result = r_result;
    assign c_out  = r_c_out;
    assign ovf    = r_ovf;
    assign zero   = ~|r_result;

endmodule

// File: tb/tb_rcas_seq_ctrl.sv
// Directed bench for rcas_seq_ctrl with hand-computed expectations.
module tb_rcas_seq_ctrl;
    import rcas_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int n_cmp  = 0;
    int n_fail = 0;

    rcas_seq_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sel    (sel),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the cycle start is presented; lat is the cycle index in which done is seen.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_op, input logic ts,
                          input bit poke, output int lat);
        a     = ta;
        b     = tb_op;
        sel   = ts;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ta;
        b     = ta;
        sel   = ~ts;
        lat   = 1;
        while (!done && lat < 30) begin
            if (poke) start = (lat == 3);
            tick();
            lat++;
        end
        start = 1'b0;
    endtask

    int lat;
    int cyc;
    int d0;
    int d1;
    int rhi;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        c0;
    logic        c1;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = OP_ADD;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero",  64'(zero),  64'd1);
        rst_n = 1'b1;
        tick();

        // Add with full carry
        run_op(32'h0000_0001, 32'hFFFF_FFFF, OP_ADD, 1'b0, lat);
        chk("add_latency", 64'(lat), 64'd9);
        chk("add_done",    64'(done), 64'd1);
        chk("add_result",  64'(result), 64'h0);
        chk("add_cout",    64'(c_out), 64'd1);
        chk("add_ovf",     64'(ovf), 64'd0);
        chk("add_zero",    64'(zero), 64'd1);
        chk("add_ready_in_done", 64'(ready), 64'd0);
        tick();
        chk("add_done_pulse", 64'(done), 64'd0);
        chk("add_ready_back", 64'(ready), 64'd1);

        // Subtract with borrow; start pulsed mid-run and again in DONE
        run_op(32'd5, 32'd7, OP_SUB, 1'b1, lat);
        chk("sub_latency", 64'(lat), 64'd9);
        chk("sub_result",  64'(result), 64'hFFFF_FFFE);
        chk("sub_cout",    64'(c_out), 64'd0);
        chk("sub_ovf",     64'(ovf), 64'd0);
        chk("sub_zero",    64'(zero), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_ignored", 64'(busy), 64'd0);
        chk("sub_result_held", 64'(result), 64'hFFFF_FFFE);
        tick();

        // Positive overflow
        run_op(32'h7FFF_FFFF, 32'd1, OP_ADD, 1'b0, lat);
        chk("povf_result", 64'(result), 64'h8000_0000);
        chk("povf_ovf",    64'(ovf), 64'd1);
        chk("povf_cout",   64'(c_out), 64'd0);
        tick();

        // Negative overflow
        run_op(32'h8000_0000, 32'd1, OP_SUB, 1'b0, lat);
        chk("novf_result", 64'(result), 64'h7FFF_FFFF);
        chk("novf_ovf",    64'(ovf), 64'd1);
        chk("novf_cout",   64'(c_out), 64'd1);
        tick();

        // Reset mid-RUN with an ignored start in between
        a     = 32'h1234_5678;
        b     = 32'h1111_1111;
        sel   = OP_ADD;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        sel   = OP_SUB;
        start = 1'b1;
        chk("run_busy",  64'(busy), 64'd1);
        chk("run_ready", 64'(ready), 64'd0);
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_ready",  64'(ready), 64'd1);
        chk("mrst_busy",   64'(busy), 64'd0);
        chk("mrst_done",   64'(done), 64'd0);
        chk("mrst_result", 64'(result), 64'h0);
        chk("mrst_zero",   64'(zero), 64'd1);
        chk("mrst_cout",   64'(c_out), 64'd0);
        chk("mrst_ovf",    64'(ovf), 64'd0);

        run_op(32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b0, lat);
        chk("reissue_latency", 64'(lat), 64'd9);
        chk("reissue_result",  64'(result), 64'h2345_6789);
        chk("reissue_cout",    64'(c_out), 64'd0);
        tick();

        // Back-to-back with start held high: 3+4 then 10-3
        a     = 32'd3;
        b     = 32'd4;
        sel   = OP_ADD;
        start = 1'b1;
        tick();
        a     = 32'd10;
        b     = 32'd3;
        sel   = OP_SUB;
        cyc   = 1;
        d0    = 0;
        d1    = 0;
        rhi   = 0;
        r0    = '0;
        r1    = '0;
        c0    = 1'b0;
        c1    = 1'b0;
        repeat (24) begin
            if (done && d0 == 0) begin
                d0 = cyc;
                r0 = result;
                c0 = c_out;
            end else if (done) begin
                d1 = cyc;
                r1 = result;
                c1 = c_out;
            end
            if (cyc < 10 && ready) rhi++;
            if (cyc == 10) chk("b2b_ready_at_10", 64'(ready), 64'd1);
            tick();
            cyc++;
            if (cyc == 11) start = 1'b0;
        end
        chk("b2b_done0_cycle", 64'(d0), 64'd9);
        chk("b2b_done1_cycle", 64'(d1), 64'd19);
        chk("b2b_result0",     64'(r0), 64'd7);
        chk("b2b_result1",     64'(r1), 64'd7);
        chk("b2b_cout0",       64'(c0), 64'd0);
        chk("b2b_cout1",       64'(c1), 64'd1);
        chk("b2b_ready_low",   64'(rhi), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
